mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit word memory port (15-bit word address, readstart/readrdy read handshake, wRAM/saverdy write handshake). It sits between the memory and its two masters: port 0 is the processor memory controller and port 1 is a secondary master (loader/DMA). It serialises their single-word reads and writes with round-robin fairness and a per-transaction timeout.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 32;
  localparam int CNT_W      = 8;

  // Default maximum number of WAIT cycles before a transaction is aborted.
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. When both ports request, the port that was
// not granted last wins. A lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Pick the winning port index from the request vector and last pointer.
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else begin
      gnt_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the shared word memory port. Serialises single
// word reads/writes from two masters with round-robin fairness and a
// per-transaction WAIT timeout.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's request
// ISSUE | one cycle: readstart pulse (read) or first write strobe cycle
// WAIT  | hold address/data, wait for the matching ready or timeout
// DONE  | one cycle: done/err pulse to the granted port, move pointer
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [MEM_ADDR_W-1:0] addr0,
  input  logic [MEM_DATA_W-1:0] wdata0,
  output logic                  done0,
  output logic                  err0,
  output logic [MEM_DATA_W-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [MEM_ADDR_W-1:0] addr1,
  input  logic [MEM_DATA_W-1:0] wdata1,
  output logic                  done1,
  output logic                  err1,
  output logic [MEM_DATA_W-1:0] rdata1,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_w,
  output logic                  mem_readstart,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  mem_readrdy,
  input  logic                  mem_saverdy
);

  arb_state_e            state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  last_q, last_d;
  logic [MEM_DATA_W-1:0] rdata0_q, rdata0_d;
  logic [MEM_DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt_idx;
  logic gnt_valid;
  logic active;

  rr_arb2 u_rr_arb2 (
    .req_i   ({req1, req0}),
    .last_i  (last_q),
    .gnt_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic: arbitration, ready/timeout handling, read capture.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ISSUE;
          port_d  = gnt_idx;
          we_d    = gnt_idx ? we1    : we0;
          addr_d  = gnt_idx ? addr1  : addr0;
          wdata_d = gnt_idx ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      WAIT: begin
        if (!we_q && mem_readrdy) begin
          state_d = DONE;
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end else if (we_q && mem_saverdy) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last allowed WAIT cycle passed without a ready.
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) begin
            if (port_q) rdata1_d = '0;
            else        rdata0_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = port_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    active        = (state_q == ISSUE) || (state_q == WAIT);
    mem_addr      = active ? addr_q : '0;
    mem_w         = active && we_q;
    mem_wdata     = (active && we_q) ? wdata_q : '0;
    mem_readstart = (state_q == ISSUE) && !we_q;
    done0         = (state_q == DONE) && !port_q;
    done1         = (state_q == DONE) && port_q;
    err0          = done0 && err_q;
    err1          = done1 && err_q;
    rdata0        = rdata0_q;
    rdata1        = rdata1_q;
  end

endmodule
